// File: rtl/control_pkg.sv
// Shared state encodings, opcode constants and class-flag bundle for the control unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package control_pkg;

   // State codes drive {s2,s1,s0} directly, so the encoding is fixed.
   typedef enum logic [2:0] {
      ST_FETCH     = 3'b000,
      ST_DECODE    = 3'b001,
      ST_EXECUTE   = 3'b011,
      ST_ACCESS    = 3'b010,
      ST_WRITEBACK = 3'b100
   } state_t;

   localparam logic [3:0] OP_ALU_LO = 4'b0000;
   localparam logic [3:0] OP_ALU_HI = 4'b0111;
   localparam logic [3:0] OP_LD     = 4'b1000;
   localparam logic [3:0] OP_ST     = 4'b1001;
   localparam logic [3:0] OP_JUMP   = 4'b1010;
   localparam logic [3:0] OP_PUSH   = 4'b1011;
   localparam logic [3:0] OP_POP    = 4'b1100;
   localparam logic [3:0] OP_BE     = 4'b1101;
   localparam logic [3:0] OP_NOP    = 4'b1110;
   localparam logic [3:0] OP_HALT   = 4'b1111;

   // One-hot instruction class flags, held from EXECUTE through WRITEBACK.
   typedef struct packed {
      logic alu;
      logic ld;
      logic st;
      logic push;
      logic pop;
      logic jump;
      logic be;
   } class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Decodes a 4-bit opcode into one-hot class flags plus a HALT indication.
// Latency: purely combinational; the sequencer registers the result.
// Backpressure: none.
module opcode_classifier
   import control_pkg::*;
(
   input  logic [3:0] i_opcode,
   output logic       o_alu,
   output logic       o_ld,
   output logic       o_st,
   output logic       o_push,
   output logic       o_pop,
   output logic       o_jump,
   output logic       o_be,
   output logic       o_is_halt
);

   // NOP and HALT leave every class flag low.
   always_comb begin
      o_alu     = 1'b0;
      o_ld      = 1'b0;
      o_st      = 1'b0;
      o_push    = 1'b0;
      o_pop     = 1'b0;
      o_jump    = 1'b0;
      o_be      = 1'b0;
      o_is_halt = 1'b0;
      case (i_opcode) inside
         [OP_ALU_LO:OP_ALU_HI]: o_alu     = 1'b1;
         OP_LD:                 o_ld      = 1'b1;
         OP_ST:                 o_st      = 1'b1;
         OP_JUMP:               o_jump    = 1'b1;
         OP_PUSH:               o_push    = 1'b1;
         OP_POP:                o_pop     = 1'b1;
         OP_BE:                 o_be      = 1'b1;
         OP_HALT:               o_is_halt = 1'b1;
         default:               ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Steps each instruction through FETCH/DECODE/EXECUTE/ACCESS/WRITEBACK, latches IR, counts retirements.
// Latency: 5 cycles per instruction minimum; HALT takes 2 cycles and parks the core until resume.
// Backpressure: holds in FETCH without instr_valid, in ACCESS (ld/pop) and WRITEBACK (st/push) without mem_ready.
module control_sequencer
   import control_pkg::*;
#(
   parameter int IW = 18,
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [IW-1:0] i_instr,
   input  logic          i_instr_valid,
   input  logic          i_mem_ready,
   input  logic          i_resume,
   output logic          o_s2,
   output logic          o_s1,
   output logic          o_s0,
   output logic          o_halted,
   output logic          o_alu,
   output logic          o_ld,
   output logic          o_st,
   output logic          o_push,
   output logic          o_pop,
   output logic          o_jump,
   output logic          o_be,
   output logic [IW-1:0] o_ir,
   output logic [CW-1:0] o_retired
);

   state_t          r_state;
   state_t          w_next;
   logic            r_halted;
   class_t          r_class;
   class_t          w_class;
   logic            w_is_halt;
   logic [IW-1:0]   r_ir;
   logic [CW-1:0]   r_retired;
   logic            w_fetch;
   logic            w_wb_exit;

   opcode_classifier u_classifier (
      .i_opcode  (r_ir[IW-1:IW-4]),
      .o_alu     (w_class.alu),
      .o_ld      (w_class.ld),
      .o_st      (w_class.st),
      .o_push    (w_class.push),
      .o_pop     (w_class.pop),
      .o_jump    (w_class.jump),
      .o_be      (w_class.be),
      .o_is_halt (w_is_halt)
   );

   // A parked core never accepts an instruction, even with instr_valid high.
   assign w_fetch   = (r_state == ST_FETCH) && !r_halted && i_instr_valid;
   assign w_wb_exit = (r_state == ST_WRITEBACK) && (!(r_class.st || r_class.push) || i_mem_ready);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_FETCH;
      else       r_state <= w_next;
   end

   // Next-state logic; mem_ready only matters in the two waiting states.
   always_comb begin
      w_next = ST_FETCH;
      case (r_state)
         ST_FETCH:     w_next = w_fetch ? ST_DECODE : ST_FETCH;
         ST_DECODE:    w_next = w_is_halt ? ST_FETCH : ST_EXECUTE;
         ST_EXECUTE:   w_next = ST_ACCESS;
         ST_ACCESS:    w_next = ((r_class.ld || r_class.pop) && !i_mem_ready) ? ST_ACCESS : ST_WRITEBACK;
         ST_WRITEBACK: w_next = w_wb_exit ? ST_FETCH : ST_WRITEBACK;
         default:      w_next = ST_FETCH;
      endcase
   end

   // IR capture, class flags, halt flag and retirement counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ir      <= '0;
         r_class   <= '0;
         r_halted  <= 1'b0;
         r_retired <= '0;
      end else begin
         if (w_fetch) r_ir <= i_instr;
         if (r_state == ST_DECODE) begin
            r_class <= w_class;
            if (w_is_halt) r_halted <= 1'b1;
         end else if (w_wb_exit) begin
            r_class   <= '0;
            r_retired <= r_retired + CW'(1);
         end
         if (r_halted && i_resume) r_halted <= 1'b0;
      end
   end

   assign {o_s2, o_s1, o_s0} = r_state;
   assign o_halted  = r_halted;
   assign o_alu     = r_class.alu;
   assign o_ld      = r_class.ld;
   assign o_st      = r_class.st;
   assign o_push    = r_class.push;
   assign o_pop     = r_class.pop;
   assign o_jump    = r_class.jump;
   assign o_be      = r_class.be;
   assign o_ir      = r_ir;
   assign o_retired = r_retired;

endmodule
